checkpoint_seq_monitor: RTL and testbench
=========================================

Name: checkpoint_seq_monitor

Overview:
- Synthesizable monitor that watches a user-project GPIO probe bus (e.g. mprj_io[31:16]) for an ordered sequence of programmable checkpoint values, with glitch filtering and a cycle timeout.
- Reports pass/fail, the failing cause, progress index and per-hit timestamps.
- Used in FPGA-side simulation and on-board FSIC validation in place of open-coded wait()/timeout blocks in benches.

Parameters:
- WIDTH, 16, probe and checkpoint value width.
- NUM_CKPT, 2, number of ordered checkpoints (>=1).
- STABLE_CYCLES, 2, consecutive sampled cycles a match must hold to count (>=1).
- TIMEOUT_CYCLES, 70000, cycles from arm to fail; 0 disables the timeout.
- CNT_W, 32, cycle counter width.
- STRICT_ORDER, 1, if 1 a stable match on a later checkpoint before the current one fails the run.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; arms (or re-arms) the monitor.
- probe  in  WIDTH  observed bus.
- ckpt_vals  in  NUM_CKPT*WIDTH  expected values; checkpoint i at [i*WIDTH +: WIDTH]. Quasi-static while busy.
- ckpt_mask  in  NUM_CKPT*WIDTH  compare mask, same packing; a 1 bit is compared.
- busy  out  1  armed and waiting.
- pass  out  1  sticky; all checkpoints hit in order.
- fail  out  1  sticky; run failed.
- fail_code  out  2  00 none, 01 timeout, 10 order violation.
- ckpt_idx  out  $clog2(NUM_CKPT+1)  index of the checkpoint currently awaited; NUM_CKPT after pass.
- hit  out  1  one-cycle pulse per checkpoint reached.
- hit_cycle  out  CNT_W  cycle_cnt value captured at the last hit.
- cycle_cnt  out  CNT_W  cycles since arm; frozen in DONE.

Behaviour:
- Reset: state IDLE; busy, pass, fail, hit = 0; fail_code = 0; ckpt_idx = 0; cycle_cnt = 0; hit_cycle = 0; probe_q = 0; match_cnt = 0.
- Probe sampling:
  - probe_q <= probe every cycle.
  - All compares use probe_q: match(i) = ((probe_q ^ val_i) & mask_i) == 0.
  - An X/Z bit under the mask evaluates as mismatch.
- States: IDLE -> WAIT on start. WAIT -> PASS on the final hit. WAIT -> FAIL on timeout or order violation. PASS/FAIL -> WAIT on start.
- start in any state, including WAIT, restarts the run:
  - next cycle: busy = 1, pass = fail = 0, fail_code = 0, ckpt_idx = 0, cycle_cnt = 0, match_cnt = 0, hit_cycle = 0.
- In WAIT, cycle_cnt increments by 1 each cycle and saturates at all-ones.
- Glitch filter (match_cnt):
  - Increments while match(ckpt_idx) holds; clears to 0 on any mismatch.
  - When match holds and match_cnt == STABLE_CYCLES-1, it is a hit.
  - A hit sets hit = 1 for one cycle, hit_cycle <= cycle_cnt, ckpt_idx += 1, match_cnt <= 0.
- Latency: if probe becomes stable-matching before edge k, hit is high in the cycle following edge k+STABLE_CYCLES.
- Consecutive checkpoints with identical masked values each need their own full STABLE_CYCLES window after the previous hit.
- Final hit (ckpt_idx == NUM_CKPT-1): PASS next cycle; pass = 1, busy = 0, ckpt_idx = NUM_CKPT.
- Order violation (STRICT_ORDER = 1):
  - A separate stability counter detects any j > ckpt_idx matching for STABLE_CYCLES while match(ckpt_idx) is false.
  - Result: FAIL, fail_code = 10.
  - If the current and a later checkpoint match simultaneously, the current checkpoint wins.
- Timeout: TIMEOUT_CYCLES != 0 and cycle_cnt == TIMEOUT_CYCLES-1 in WAIT -> FAIL, fail_code = 01.
- Priority in the same cycle: final hit over timeout over order violation. start overrides all.
- In PASS/FAIL the outputs hold, the probe is ignored and hit stays 0.
- ap_rst asserted mid-run returns immediately to the reset values.

Test Plan:
- WIDTH=16, NUM_CKPT=2, vals {AB61,AB60}, masks FFFF, STABLE=2, TIMEOUT=100; start, probe=AB60 at cycle 5, AB61 at cycle 20 -> hit at ~cycle 8 and ~23, ckpt_idx 0->1->2, pass=1, fail=0.
- Same config; probe glitches to AB60 for exactly 1 cycle, then 0000 -> no hit, match_cnt clears; timeout at cycle_cnt=99 -> fail=1, fail_code=01, busy=0.
- STRICT_ORDER=1; probe=AB61 held 3 cycles before any AB60 -> fail=1, fail_code=10, ckpt_idx=0.
- mask0=FF00, val0=AB00; probe=AB5A held 2 cycles -> hit, ckpt_idx=1.
- Final stable match landing on the timeout cycle -> pass=1, fail=0. With TIMEOUT_CYCLES=0, 10000 idle cycles -> busy stays 1, no fail.
- ap_rst pulse at cycle 10 of a run -> all outputs return to reset values. Restart with start mid-WAIT -> cycle_cnt=0 and ckpt_idx=0 the next cycle.

Source files
------------

// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor: watches a probe bus for an ordered sequence of masked checkpoint values
//   ap_clk, ap_rst     clock, asynchronous active-high reset
//   start              one-cycle pulse that arms or re-arms a run
//   probe              observed bus, registered once before any compare
//   ckpt_vals/mask     NUM_CKPT packed values and compare masks, checkpoint i at [i*WIDTH +: WIDTH]
//   busy/pass/fail     run state; pass and fail are sticky until the next start
//   fail_code          00 none, 01 timeout, 10 order violation
//   ckpt_idx           checkpoint currently awaited, NUM_CKPT after pass
//   hit, hit_cycle     one-cycle pulse per checkpoint reached and cycle_cnt captured at that hit
//   cycle_cnt          saturating cycles since arm, frozen once the run ends
module checkpoint_seq_monitor #(
    parameter int WIDTH          = 16,
    parameter int NUM_CKPT       = 2,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int CNT_W          = 32,
    parameter int STRICT_ORDER   = 1
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             start,
    input  logic [WIDTH-1:0]                 probe,
    input  logic [NUM_CKPT*WIDTH-1:0]        ckpt_vals,
    input  logic [NUM_CKPT*WIDTH-1:0]        ckpt_mask,
    output logic                             busy,
    output logic                             pass,
    output logic                             fail,
    output logic [1:0]                       fail_code,
    output logic [$clog2(NUM_CKPT+1)-1:0]    ckpt_idx,
    output logic                             hit,
    output logic [CNT_W-1:0]                 hit_cycle,
    output logic [CNT_W-1:0]                 cycle_cnt
);
    localparam int IW = $clog2(NUM_CKPT + 1);
    localparam int MW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [MW-1:0] MC_LAST = MW'(STABLE_CYCLES - 1);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] probe_q;
    logic [MW-1:0] match_cnt, ord_cnt;
    logic [NUM_CKPT-1:0] m;
    logic cur_match, later_match, hit_ev, final_ev, to_ev, ord_ev, adv;
    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_match
        assign m[g] = ((probe_q ^ ckpt_vals[g*WIDTH +: WIDTH]) & ckpt_mask[g*WIDTH +: WIDTH]) == '0;
    end
    // the awaited checkpoint and any later one are tracked separately so a simultaneous match favours the current one
    always_comb begin
        cur_match = 1'b0;
        later_match = 1'b0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (i == int'(ckpt_idx)) cur_match = m[i];
            if (i > int'(ckpt_idx)) later_match = later_match | m[i];
        end
    end
    assign hit_ev   = (state == S_WAIT) && cur_match && (match_cnt == MC_LAST);
    assign final_ev = hit_ev && (ckpt_idx == IW'(NUM_CKPT - 1));
    assign to_ev    = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) && (cycle_cnt == TO_LAST);
    assign ord_ev   = (STRICT_ORDER != 0) && (state == S_WAIT) && later_match && !cur_match && (ord_cnt == MC_LAST);
    // a timeout swallows a non-final hit landing on the same cycle
    assign adv      = hit_ev && (final_ev || !to_ev);
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_d;
    end
    always_comb begin
        state_d = start ? S_WAIT :
                  (state != S_WAIT) ? state :
                  final_ev ? S_PASS :
                  (to_ev || ord_ev) ? S_FAIL : S_WAIT;
    end
    always_comb begin
        busy = state == S_WAIT;
        pass = state == S_PASS;
        fail = state == S_FAIL;
    end
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            probe_q   <= '0;
            match_cnt <= '0;
            ord_cnt   <= '0;
            ckpt_idx  <= '0;
            cycle_cnt <= '0;
            hit_cycle <= '0;
            hit       <= 1'b0;
            fail_code <= 2'b00;
        end else begin
            probe_q <= probe;
            if (start) begin
                match_cnt <= '0;
                ord_cnt   <= '0;
                ckpt_idx  <= '0;
                cycle_cnt <= '0;
                hit_cycle <= '0;
                hit       <= 1'b0;
                fail_code <= 2'b00;
            end else if (state == S_WAIT) begin
                cycle_cnt <= &cycle_cnt ? cycle_cnt : cycle_cnt + CNT_W'(1);
                hit       <= adv;
                match_cnt <= (cur_match && !adv) ? match_cnt + MW'(1) : '0;
                ord_cnt   <= (later_match && !cur_match) ? ord_cnt + MW'(1) : '0;
                if (adv) begin
                    hit_cycle <= cycle_cnt;
                    ckpt_idx  <= ckpt_idx + IW'(1);
                end
                if (!final_ev) fail_code <= to_ev ? 2'b01 : ord_ev ? 2'b10 : 2'b00;
            end else begin
                hit <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// tb_checkpoint_seq_monitor: scoreboard bench for checkpoint_seq_monitor
module tb_checkpoint_seq_monitor;
    logic        ap_clk = 1'b0;
    logic        ap_rst, start, start_b;
    logic [15:0] probe, probe_b;
    logic [31:0] vals, mask;
    logic        busy, pass, fail, hit;
    logic [1:0]  fail_code;
    logic [1:0]  ckpt_idx;
    logic [31:0] hit_cycle, cycle_cnt;
    logic        busy_b, pass_b, fail_b, hit_b;
    logic [1:0]  fail_code_b;
    logic [1:0]  ckpt_idx_b;
    logic [31:0] hit_cycle_b, cycle_cnt_b;
    int checks = 0;
    int failures = 0;
    bit prev_done = 1'b0;
    typedef struct {
        bit        done;
        bit        pass;
        logic [1:0] code;
        int        idx;
        int        hc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 ap_clk = ~ap_clk;

    checkpoint_seq_monitor #(.WIDTH(16), .NUM_CKPT(2), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(100),
                             .CNT_W(32), .STRICT_ORDER(1)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .probe(probe),
        .ckpt_vals(vals), .ckpt_mask(mask), .busy(busy), .pass(pass), .fail(fail),
        .fail_code(fail_code), .ckpt_idx(ckpt_idx), .hit(hit), .hit_cycle(hit_cycle),
        .cycle_cnt(cycle_cnt));

    checkpoint_seq_monitor #(.WIDTH(16), .NUM_CKPT(2), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(0),
                             .CNT_W(32), .STRICT_ORDER(1)) dut_nt (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start_b), .probe(probe_b),
        .ckpt_vals(vals), .ckpt_mask(mask), .busy(busy_b), .pass(pass_b), .fail(fail_b),
        .fail_code(fail_code_b), .ckpt_idx(ckpt_idx_b), .hit(hit_b), .hit_cycle(hit_cycle_b),
        .cycle_cnt(cycle_cnt_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input bit done, input bit ps, input logic [1:0] code, input int idx, input int hc);
        exp_t x;
        x.done = done;
        x.pass = ps;
        x.code = code;
        x.idx  = idx;
        x.hc   = hc;
        sb.push_back(x);
    endtask

    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (hit) begin
                if (sb.size() == 0) chk("unexpected_hit", 64'(hit), 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("hit_kind", 64'(e.done), 64'd0);
                    chk("hit_idx", 64'(ckpt_idx), 64'(e.idx));
                    chk("hit_cycle", 64'(hit_cycle), 64'(e.hc));
                end
            end
            if ((pass || fail) && !prev_done) begin
                if (sb.size() == 0) chk("unexpected_done", 64'(pass || fail), 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("done_kind", 64'(e.done), 64'd1);
                    chk("done_pass", 64'(pass), 64'(e.pass));
                    chk("done_fail", 64'(fail), 64'(!e.pass));
                    chk("done_code", 64'(fail_code), 64'(e.code));
                    chk("done_idx", 64'(ckpt_idx), 64'(e.idx));
                    chk("done_busy", 64'(busy), 64'd0);
                end
            end
        end
        prev_done = pass || fail;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_code"}, 64'(fail_code), 64'd0);
        chk({tag, "_idx"}, 64'(ckpt_idx), 64'd0);
        chk({tag, "_hit"}, 64'(hit), 64'd0);
        chk({tag, "_hit_cycle"}, 64'(hit_cycle), 64'd0);
        chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    endtask

    initial begin
        ap_rst = 1'b1;
        start = 1'b0;
        start_b = 1'b0;
        probe = 16'h0000;
        probe_b = 16'h0000;
        vals = {16'hAB61, 16'hAB60};
        mask = {16'hFFFF, 16'hFFFF};
        repeat (3) tick();
        chk_reset("rst");
        ap_rst = 1'b0;
        tick();

        // in-order pass: AB60 from cycle 5, AB61 from cycle 20
        push(0, 0, 2'b00, 1, 7);
        push(0, 0, 2'b00, 2, 22);
        push(1, 1, 2'b00, 2, 0);
        arm();
        repeat (5) tick();
        probe = 16'hAB60;
        repeat (15) tick();
        probe = 16'hAB61;
        repeat (8) tick();

        // single-cycle glitch is filtered, run times out at cycle_cnt 99
        probe = 16'h0000;
        push(1, 0, 2'b01, 0, 0);
        arm();
        repeat (3) tick();
        probe = 16'hAB60;
        tick();
        probe = 16'h0000;
        repeat (105) tick();
        chk("to_busy", 64'(busy), 64'd0);

        // later checkpoint stable first: order violation
        push(1, 0, 2'b10, 0, 0);
        arm();
        repeat (2) tick();
        probe = 16'hAB61;
        repeat (3) tick();
        probe = 16'h0000;
        repeat (5) tick();

        // masked compare, two identical checkpoints need separate windows
        vals = {16'hAB00, 16'hAB00};
        mask = {16'hFF00, 16'hFF00};
        tick();
        push(0, 0, 2'b00, 1, 3);
        push(0, 0, 2'b00, 2, 5);
        push(1, 1, 2'b00, 2, 0);
        arm();
        tick();
        probe = 16'hAB5A;
        repeat (10) tick();

        // final hit lands exactly on the timeout cycle: pass wins
        probe = 16'h0000;
        vals = {16'hAB61, 16'hAB60};
        mask = {16'hFFFF, 16'hFFFF};
        tick();
        push(0, 0, 2'b00, 1, 7);
        push(0, 0, 2'b00, 2, 99);
        push(1, 1, 2'b00, 2, 0);
        arm();
        repeat (5) tick();
        probe = 16'hAB60;
        repeat (92) tick();
        probe = 16'hAB61;
        repeat (8) tick();

        // asynchronous reset mid-run at cycle 10
        probe = 16'h0000;
        push(0, 0, 2'b00, 1, 4);
        arm();
        repeat (2) tick();
        probe = 16'hAB60;
        repeat (8) tick();
        chk("mid_idx", 64'(ckpt_idx), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        ap_rst = 1'b1;
        #1;
        chk_reset("async_rst");
        tick();
        ap_rst = 1'b0;
        probe = 16'h0000;
        tick();

        // start while waiting restarts the run
        push(0, 0, 2'b00, 1, 3);
        arm();
        tick();
        probe = 16'hAB60;
        repeat (6) tick();
        chk("pre_restart_idx", 64'(ckpt_idx), 64'd1);
        probe = 16'h0000;
        tick();
        arm();
        chk("restart_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("restart_idx", 64'(ckpt_idx), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_hit_cycle", 64'(hit_cycle), 64'd0);
        push(1, 0, 2'b01, 0, 0);
        repeat (105) tick();

        // timeout disabled: stays busy indefinitely
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (10000) tick();
        chk("nt_busy", 64'(busy_b), 64'd1);
        chk("nt_fail", 64'(fail_b), 64'd0);
        chk("nt_pass", 64'(pass_b), 64'd0);
        chk("nt_cycle_cnt", 64'(cycle_cnt_b), 64'd10000);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
